// File: rtl/o_counter.sv
// ---------------------------------------------------------------------------
// o_counter
//
// Raster position tracker for the scope-video capture path. Follows the
// scope pixel clock and its active-low HSYNC/VSYNC, and produces:
//   - visible-relative pixel coordinates inside a fixed capture window,
//   - a visible strobe used downstream as BRAM write enable / address step,
//   - a frame-lock indicator (SYNC),
//   - a 50 % duty heartbeat toggling every HALF_PERIOD_FRAMES frames.
//
// Ports
//   O_CLK      in   scope pixel clock, all state on its rising edge
//   O_RST_N    in   asynchronous active-low reset
//   ENABLE     in   capture enable (gates O_VISIBLE/O_X/O_Y only)
//   O_HS       in   horizontal sync, active-low
//   O_VS       in   vertical sync, active-low
//   O_X        out  [9:0] visible-relative column (0 outside window)
//   O_Y        out  [8:0] visible-relative row    (0 outside window)
//   O_VISIBLE  out  current pixel inside the capture window
//   PULSE_1HZ  out  heartbeat square wave derived from the frame rate
//   SYNC       out  frame timing locked
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// o_counter_edge
//
// One sync input: registers the level once and flags the falling edge in the
// cycle where the low level is first sampled. The delayed copy resets high so
// a sync input that is already low out of reset still produces an edge.
//
// Ports
//   O_CLK    in   pixel clock
//   O_RST_N  in   asynchronous active-low reset
//   din      in   raw sync level
//   fall     out  din low now, high on the previous sample
// ---------------------------------------------------------------------------
module o_counter_edge (
    input  logic O_CLK,
    input  logic O_RST_N,
    input  logic din,
    output logic fall
);

    logic din_d;

    always_ff @(posedge O_CLK or negedge O_RST_N) begin
        if (!O_RST_N) din_d <= 1'b1;
        else          din_d <= din;
    end

    assign fall = ~din & din_d;

endmodule

module o_counter #(
    parameter int H_START            = 100,
    parameter int H_VISIBLE          = 576,
    parameter int V_START            = 20,
    parameter int V_VISIBLE          = 368,
    parameter int HALF_PERIOD_FRAMES = 30,
    parameter int LOCK_FRAMES        = 2
) (
    input  logic       O_CLK,
    input  logic       O_RST_N,
    input  logic       ENABLE,
    input  logic       O_HS,
    input  logic       O_VS,
    output logic [9:0] O_X,
    output logic [8:0] O_Y,
    output logic       O_VISIBLE,
    output logic       PULSE_1HZ,
    output logic       SYNC
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int NUM_SYNC = 2;
    localparam int SYNC_HS  = 0;
    localparam int SYNC_VS  = 1;

    localparam logic [9:0] HCNT_MAX = 10'h3FF;
    localparam logic [8:0] VCNT_MAX = 9'h1FF;

    // Window bounds carry one spare bit so H_START+H_VISIBLE = 1024 (or
    // V_START+V_VISIBLE = 512) still forms a valid exclusive upper bound.
    localparam logic [10:0] H_LO  = 11'(H_START);
    localparam logic [10:0] H_HI  = 11'(H_START + H_VISIBLE);
    localparam logic [9:0]  V_LO  = 10'(V_START);
    localparam logic [9:0]  V_HI  = 10'(V_START + V_VISIBLE);
    localparam logic [9:0]  H_OFS = 10'(H_START);
    localparam logic [8:0]  V_OFS = 9'(V_START);

    localparam int MW = (LOCK_FRAMES > 0) ? $clog2(LOCK_FRAMES + 1) : 1;
    localparam int FW = (HALF_PERIOD_FRAMES > 1) ? $clog2(HALF_PERIOD_FRAMES) : 1;

    localparam logic [MW-1:0] LOCK_M  = MW'(LOCK_FRAMES);
    localparam logic [FW-1:0] FC_LAST = FW'(HALF_PERIOD_FRAMES - 1);

    // ------------------------------------------------------------------
    // Sync edge detection
    // ------------------------------------------------------------------
    logic [NUM_SYNC-1:0] sync_lvl;
    logic [NUM_SYNC-1:0] sync_fall;
    logic                hs_fall;
    logic                vs_fall;

    assign sync_lvl = {O_VS, O_HS};

    generate
        for (genvar g = 0; g < NUM_SYNC; g++) begin : g_edge
            o_counter_edge u_edge (
                .O_CLK   (O_CLK),
                .O_RST_N (O_RST_N),
                .din     (sync_lvl[g]),
                .fall    (sync_fall[g])
            );
        end
    endgenerate

    assign hs_fall = sync_fall[SYNC_HS];
    assign vs_fall = sync_fall[SYNC_VS];

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [9:0] hcnt, hcnt_nxt;
    logic [8:0] vcnt, vcnt_nxt;

    always_comb begin
        hcnt_nxt = hcnt;
        if (hs_fall)               hcnt_nxt = '0;
        else if (hcnt != HCNT_MAX) hcnt_nxt = hcnt + 10'd1;
    end

    // VS edge takes priority over a coincident HS edge so the first line of
    // a frame is row 0, not row 1.
    always_comb begin
        vcnt_nxt = vcnt;
        if (vs_fall)                           vcnt_nxt = '0;
        else if (hs_fall && vcnt != VCNT_MAX)  vcnt_nxt = vcnt + 9'd1;
    end

    always_ff @(posedge O_CLK or negedge O_RST_N) begin
        if (!O_RST_N) begin
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            hcnt <= hcnt_nxt;
            vcnt <= vcnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Frame lock
    // ------------------------------------------------------------------
    // A frame qualifies when its line count repeats the previous one, is
    // long enough to contain the whole window, and the row counter never
    // pinned at its ceiling (which would mean VS went missing).
    logic [8:0]    prev_vcnt;
    logic          sat_q;
    logic [MW-1:0] match_q, match_nxt;
    logic          sync_q;
    logic          frame_good;
    logic          vs_lost;

    assign frame_good = (vcnt == prev_vcnt) && ({1'b0, vcnt} >= V_HI) && !sat_q;
    assign vs_lost    = ~vs_fall & (vcnt_nxt == VCNT_MAX);

    always_comb begin
        match_nxt = '0;
        if (frame_good) match_nxt = (match_q == LOCK_M) ? match_q : match_q + MW'(1);
    end

    // ------------------------------------------------------------------
    // Heartbeat
    // ------------------------------------------------------------------
    logic [FW-1:0] frame_cnt;
    logic          pulse_q;

    always_ff @(posedge O_CLK or negedge O_RST_N) begin
        if (!O_RST_N) begin
            prev_vcnt <= '0;
            sat_q     <= 1'b0;
            match_q   <= '0;
            sync_q    <= 1'b0;
            frame_cnt <= '0;
            pulse_q   <= 1'b0;
        end else if (vs_fall) begin
            prev_vcnt <= vcnt;
            sat_q     <= 1'b0;
            match_q   <= match_nxt;
            sync_q    <= (match_nxt == LOCK_M);
            if (frame_cnt == FC_LAST) begin
                frame_cnt <= '0;
                pulse_q   <= ~pulse_q;
            end else begin
                frame_cnt <= frame_cnt + FW'(1);
            end
        end else if (vs_lost) begin
            // Drop lock in the same cycle the row counter pins, not at the
            // next VS edge, which may never come.
            sat_q   <= 1'b1;
            match_q <= '0;
            sync_q  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Window decode (combinational so O_VS low masks with zero latency)
    // ------------------------------------------------------------------
    logic in_h, in_v;

    assign in_h = ({1'b0, hcnt} >= H_LO) && ({1'b0, hcnt} < H_HI);
    assign in_v = ({1'b0, vcnt} >= V_LO) && ({1'b0, vcnt} < V_HI);

    assign O_VISIBLE = ENABLE & O_VS & in_h & in_v;
    assign O_X       = O_VISIBLE ? (hcnt - H_OFS) : '0;
    assign O_Y       = O_VISIBLE ? (vcnt - V_OFS) : '0;
    assign SYNC      = sync_q;
    assign PULSE_1HZ = pulse_q;

endmodule

// File: tb/tb_o_counter.sv
// ---------------------------------------------------------------------------
// tb_o_counter
//
// Drives a scaled-down raster (40-clock lines, 4-clock HS, 12-line frames,
// VS low for the first 2 lines) and scoreboards every pixel clock against a
// reference derived from the generator's own line/pixel position.
// ---------------------------------------------------------------------------
module tb_o_counter;

    localparam int H_START   = 10;
    localparam int H_VISIBLE = 20;
    localparam int V_START   = 3;
    localparam int V_VISIBLE = 6;
    localparam int HALF      = 4;
    localparam int LOCK      = 2;

    localparam int LINE      = 40;
    localparam int HS_LEN    = 4;
    localparam int VSL       = 2;
    localparam int FRAME     = 12;
    localparam int FULL_CNT  = H_VISIBLE * V_VISIBLE;

    logic       O_CLK = 1'b0;
    logic       O_RST_N;
    logic       ENABLE;
    logic       O_HS;
    logic       O_VS;
    logic [9:0] O_X;
    logic [8:0] O_Y;
    logic       O_VISIBLE;
    logic       PULSE_1HZ;
    logic       SYNC;

    o_counter #(
        .H_START            (H_START),
        .H_VISIBLE          (H_VISIBLE),
        .V_START            (V_START),
        .V_VISIBLE          (V_VISIBLE),
        .HALF_PERIOD_FRAMES (HALF),
        .LOCK_FRAMES        (LOCK)
    ) dut (
        .O_CLK     (O_CLK),
        .O_RST_N   (O_RST_N),
        .ENABLE    (ENABLE),
        .O_HS      (O_HS),
        .O_VS      (O_VS),
        .O_X       (O_X),
        .O_Y       (O_Y),
        .O_VISIBLE (O_VISIBLE),
        .PULSE_1HZ (PULSE_1HZ),
        .SYNC      (SYNC)
    );

    always #5 O_CLK = ~O_CLK;

    typedef struct packed {
        logic       vis;
        logic [9:0] x;
        logic [8:0] y;
        logic       sync;
        logic       pulse;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int fails  = 0;

    // Reference state, driven purely by generator position.
    bit en;
    int vc;
    bit prev_vs_low;
    int edges;
    int prev_f;
    bit good_hist[$];
    bit sync_e;
    bit pulse_e;
    bit sat_e;
    int vis_cnt;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        vc          = 0;
        prev_vs_low = 1'b0;
        edges       = 0;
        prev_f      = 0;
        good_hist.delete();
        sync_e      = 1'b0;
        pulse_e     = 1'b0;
        sat_e       = 1'b0;
    endtask

    // One pixel clock at position p of the current line.
    task automatic pix(input int p, input bit vs_low);
        exp_t e;
        exp_t got;
        int   f;
        bit   g;
        @(negedge O_CLK);
        O_HS   = (p >= HS_LEN);
        O_VS   = !vs_low;
        ENABLE = en;
        if (p == 0) begin
            if (vs_low && !prev_vs_low) begin
                f      = vc;
                g      = (f == prev_f) && (f >= V_START + V_VISIBLE) && !sat_e;
                prev_f = f;
                good_hist.push_back(g);
                edges++;
                sync_e = 1'b0;
                if (good_hist.size() >= LOCK) begin
                    sync_e = 1'b1;
                    for (int i = 0; i < LOCK; i++)
                        if (!good_hist[good_hist.size() - 1 - i]) sync_e = 1'b0;
                end
                pulse_e = ((edges / HALF) % 2) == 1;
                vc      = 0;
                sat_e   = 1'b0;
            end else begin
                if (vc < 511) vc++;
                if (vc == 511) begin
                    sat_e  = 1'b1;
                    sync_e = 1'b0;
                end
            end
            prev_vs_low = vs_low;
        end
        e.vis   = en && !vs_low && p >= H_START && p < H_START + H_VISIBLE &&
                  vc >= V_START && vc < V_START + V_VISIBLE;
        e.x     = e.vis ? 10'(p - H_START) : 10'd0;
        e.y     = e.vis ? 9'(vc - V_START) : 9'd0;
        e.sync  = sync_e;
        e.pulse = pulse_e;
        sb.push_back(e);
        @(posedge O_CLK);
        #1;
        e   = sb.pop_front();
        got = {O_VISIBLE, O_X, O_Y, SYNC, PULSE_1HZ};
        chk("pix", 32'(got), 32'(e));
        if (O_VISIBLE) vis_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) pix(LINE - 1, 1'b0);
    endtask

    // en_line/en_pix: position where ENABLE goes high (-1 = never switch).
    task automatic frame(input int nl, input int en_line, input int en_pix, input int exp_cnt);
        vis_cnt = 0;
        for (int l = 0; l < nl; l++)
            for (int p = 0; p < LINE; p++) begin
                if (l == en_line && p == en_pix) en = 1'b1;
                pix(p, l < VSL);
            end
        if (exp_cnt >= 0) chk("vis_count", vis_cnt, exp_cnt);
    endtask

    initial begin
        O_RST_N = 1'b0;
        O_HS    = 1'b1;
        O_VS    = 1'b1;
        en      = 1'b1;
        ENABLE  = 1'b1;
        model_reset();
        #23;
        chk("rst_vis",   32'(O_VISIBLE), 32'd0);
        chk("rst_x",     32'(O_X),       32'd0);
        chk("rst_y",     32'(O_Y),       32'd0);
        chk("rst_sync",  32'(SYNC),      32'd0);
        chk("rst_pulse", 32'(PULSE_1HZ), 32'd0);
        @(negedge O_CLK);
        O_RST_N = 1'b1;
        idle(20);

        // Lock acquisition with identical frames.
        for (int i = 0; i < 5; i++) frame(FRAME, -1, 0, FULL_CNT);
        chk("sync_locked", 32'(SYNC), 32'd1);

        // Short frame breaks the lock at the edge that ends it.
        frame(10, -1, 0, FULL_CNT);
        frame(FRAME, -1, 0, FULL_CNT);
        chk("sync_short", 32'(SYNC), 32'd0);
        for (int i = 0; i < 3; i++) frame(FRAME, -1, 0, FULL_CNT);
        chk("sync_relock", 32'(SYNC), 32'd1);

        // Capture disabled for a whole frame, then re-enabled mid-line.
        en = 1'b0;
        frame(FRAME, -1, 0, 0);
        chk("sync_disabled", 32'(SYNC), 32'd1);
        frame(FRAME, 5, 20, 10 + 3 * H_VISIBLE);

        // Reset in the middle of a visible line.
        for (int l = 0; l < 5; l++)
            for (int p = 0; p < LINE; p++) pix(p, l < VSL);
        for (int p = 0; p < 15; p++) pix(p, 1'b0);
        chk("pre_rst_vis", 32'(O_VISIBLE), 32'd1);
        @(negedge O_CLK);
        O_HS = 1'b1;
        #2;
        O_RST_N = 1'b0;
        #1;
        chk("mid_rst_vis",   32'(O_VISIBLE), 32'd0);
        chk("mid_rst_x",     32'(O_X),       32'd0);
        chk("mid_rst_y",     32'(O_Y),       32'd0);
        chk("mid_rst_sync",  32'(SYNC),      32'd0);
        chk("mid_rst_pulse", 32'(PULSE_1HZ), 32'd0);
        repeat (3) @(posedge O_CLK);
        @(negedge O_CLK);
        O_RST_N = 1'b1;
        model_reset();
        idle(10);

        // Lock needs LOCK+1 complete frames after reset.
        for (int i = 0; i < 3; i++) frame(FRAME, -1, 0, FULL_CNT);
        chk("sync_after3", 32'(SYNC), 32'd0);
        frame(FRAME, -1, 0, FULL_CNT);
        chk("sync_after4", 32'(SYNC), 32'd1);

        // VS lost while HS keeps running: row counter pins, lock drops.
        for (int l = 0; l < 520; l++)
            for (int p = 0; p < LINE; p++) pix(p, 1'b0);
        chk("sync_vs_lost", 32'(SYNC), 32'd0);

        for (int i = 0; i < 4; i++) frame(FRAME, -1, 0, FULL_CNT);
        chk("sync_recover", 32'(SYNC), 32'd1);
        chk("pulse_8edges", 32'(PULSE_1HZ), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
